// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative shift-add multiplier / restoring divider owning the HI/LO pair.
// Define HILO_MULDIV_DIV_EN to compile in the divider datapath and the DIV/DIVU opcodes.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_FIN = 2'd2} state_e;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic               accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_res;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready && !cancel;

  // Signed opcodes (MULT, DIV) are the even codes; only they take magnitudes.
  assign a_neg = ~req_op[0] & req_a[WIDTH-1];
  assign b_neg = ~req_op[0] & req_b[WIDTH-1];
  assign a_mag = a_neg ? -req_a : req_a;
  assign b_mag = b_neg ? -req_b : req_b;

  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : '0);
  assign prod_res = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

`ifdef HILO_MULDIV_DIV_EN
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_DIVU = 3'b011;

  logic             is_div_q, is_div_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub, quo_res, rem_res;

  // Partial remainder stays below the divisor, so the difference always fits WIDTH bits.
  assign div_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge  = (div_sh >= {1'b0, opd_q});
  assign div_sub = WIDTH'(div_sh - {1'b0, opd_q});
  assign quo_res = neg_q ? -acc_lo_q : acc_lo_q;
  assign rem_res = neg_rem_q ? -acc_hi_q : acc_hi_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opd_d    = opd_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    busy_d   = 1'b0;
`ifdef HILO_MULDIV_DIV_EN
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
    a_raw_d   = a_raw_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_MTHI: begin
              hi_d   = req_a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = req_a;
              done_d = 1'b1;
            end
            OP_MULT, OP_MULTU: begin
              state_d  = S_BUSY;
              cnt_d    = '0;
              busy_d   = 1'b1;
              acc_hi_d = '0;
              acc_lo_d = b_mag;
              opd_d    = a_mag;
              neg_d    = a_neg ^ b_neg;
`ifdef HILO_MULDIV_DIV_EN
              is_div_d = 1'b0;
`endif
            end
`ifdef HILO_MULDIV_DIV_EN
            OP_DIV, OP_DIVU: begin
              state_d   = S_BUSY;
              cnt_d     = '0;
              busy_d    = 1'b1;
              acc_hi_d  = '0;
              acc_lo_d  = a_mag;
              opd_d     = b_mag;
              neg_d     = a_neg ^ b_neg;
              is_div_d  = 1'b1;
              neg_rem_d = a_neg;
              a_raw_d   = req_a;
            end
`endif
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          busy_d   = (cnt_q != CNT_LAST);
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`ifdef HILO_MULDIV_DIV_EN
          if (is_div_q) begin
            acc_hi_d = div_ge ? div_sub : div_sh[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
          end
`endif
          if (cnt_q == CNT_LAST) state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          hi_d   = prod_res[2*WIDTH-1:WIDTH];
          lo_d   = prod_res[WIDTH-1:0];
`ifdef HILO_MULDIV_DIV_EN
          if (is_div_q) begin
            // Zero divisor: quotient saturates, dividend passes through untouched.
            if (opd_q == '0) begin
              hi_d = a_raw_q;
              lo_d = '1;
            end else begin
              hi_d = rem_res;
              lo_d = quo_res;
            end
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opd_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef HILO_MULDIV_DIV_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      a_raw_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opd_q    <= opd_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef HILO_MULDIV_DIV_EN
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
      a_raw_q   <= a_raw_d;
`endif
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit at WIDTH=32; divide vectors follow HILO_MULDIV_DIV_EN.
module tb_hilo_muldiv_unit;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_checks = 0;
  int n_errors = 0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
  endtask

  // Called in cycle N+1; lat reports k where done seen in cycle N+k (0 = timeout).
  task automatic wait_done(output int lat, output int n_busy, output int n_nrdy);
    lat = 0;
    n_busy = 0;
    n_nrdy = 0;
    for (int k = 1; k <= 60; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy) n_busy++;
      if (!req_ready) n_nrdy++;
      tick();
    end
  endtask

  task automatic run_vec(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int lat, nb, nr;
    issue(op, a, b);
    wait_done(lat, nb, nr);
    chk({tag, "_lat"}, 64'(lat), 64'd34);
    chk({tag, "_busy_cycles"}, 64'(nb), 64'd32);
    chk({tag, "_nrdy_cycles"}, 64'(nr), 64'd33);
    chk({tag, "_rdy_at_done"}, 64'(req_ready), 64'd1);
    chk({tag, "_hi"}, 64'(hi_out), 64'(ehi));
    chk({tag, "_lo"}, 64'(lo_out), 64'(elo));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nb, nr, n_done;
    rst = 1'b1; req_valid = 1'b0; req_op = OP_NOP; req_a = '0; req_b = '0; cancel = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    tick();

    run_vec("mult_m3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    tick();
    chk("done_pulse_one_cycle", 64'(done), 64'd0);
    run_vec("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_vec("mult_minxmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run_vec("mult_negxneg", OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0, 32'd6);
    run_vec("mult_maxxm1", OP_MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001);
    run_vec("multu_carry", OP_MULTU, 32'h8000_0000, 32'd2, 32'd1, 32'd0);

`ifdef HILO_MULDIV_DIV_EN
    run_vec("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_vec("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_vec("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_vec("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_vec("div_m7_0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_vec("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
`else
    tick();
    issue(OP_DIVU, 32'd100, 32'd7);
    chk("nodiv_ready", 64'(req_ready), 64'd1);
    chk("nodiv_busy", 64'(busy), 64'd0);
    chk("nodiv_done", 64'(done), 64'd0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy || !req_ready) n_done++;
      tick();
    end
    chk("nodiv_no_activity", 64'(n_done), 64'd0);
    chk("nodiv_hi", 64'(hi_out), 64'd1);
    chk("nodiv_lo", 64'(lo_out), 64'd0);
`endif

    run_vec("multu_3x5", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    chk("mthi_hi", 64'(hi_out), 64'h1234_5678);
    chk("mthi_lo", 64'(lo_out), 64'd15);
    chk("mthi_done", 64'(done), 64'd1);
    chk("mthi_ready", 64'(req_ready), 64'd1);
    tick();
    chk("mthi_done_clear", 64'(done), 64'd0);

    // MTLO held valid while MULT runs: accepted only in the MULT done cycle.
    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd6; req_b = 32'd7;
    tick();
    req_op = OP_MTLO; req_a = 32'hCAFE_F00D; req_b = 32'd0;
    wait_done(lat, nb, nr);
    chk("hold_lat", 64'(lat), 64'd34);
    chk("hold_mult_hi", 64'(hi_out), 64'd0);
    chk("hold_mult_lo", 64'(lo_out), 64'd42);
    tick();
    req_valid = 1'b0;
    chk("hold_mtlo_lo", 64'(lo_out), 64'hCAFE_F00D);
    chk("hold_mtlo_hi", 64'(hi_out), 64'd0);
    chk("hold_mtlo_done", 64'(done), 64'd1);
    tick();

    issue(OP_NOP, 32'hDEAD_BEEF, 32'd1);
    chk("nop_done", 64'(done), 64'd0);
    chk("nop_ready", 64'(req_ready), 64'd1);
    chk("nop_lo", 64'(lo_out), 64'hCAFE_F00D);

    cancel = 1'b1;
    issue(OP_MTHI, 32'h0000_DEAD, 32'd0);
    cancel = 1'b0;
    chk("idle_cancel_done", 64'(done), 64'd0);
    chk("idle_cancel_hi", 64'(hi_out), 64'd0);

    issue(OP_MULT, 32'd3, 32'd4);
    repeat (9) tick();
    chk("cancel_busy10", 64'(busy), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    chk("cancel_ready", 64'(req_ready), 64'd1);
    chk("cancel_done", 64'(done), 64'd0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) n_done++;
      tick();
    end
    chk("cancel_no_done", 64'(n_done), 64'd0);
    chk("cancel_hi", 64'(hi_out), 64'd0);
    chk("cancel_lo", 64'(lo_out), 64'hCAFE_F00D);

    issue(OP_MULT, 32'd3, 32'd4);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_hi", 64'(hi_out), 64'd0);
    chk("midrst_lo", 64'(lo_out), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd1);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);

    run_vec("mult_3x4", OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12);
    run_vec("b2b_multu_2x3", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
